// File: rtl/tff_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tff_counter_ctrl
//
// Control stage for a chain of falling-edge T flip-flops with asynchronous
// per-bit CLR/PRESET. The pair forms a presettable up/down modulo counter that
// counts 0..MAX. This block looks at the chain's Q vector, decides which bits
// must toggle on the next falling edge, and sequences parallel loads by holding
// per-bit clear/preset for one cycle.
//
// All state changes on the rising edge of CLK. The toggle enables are
// therefore stable for half a cycle before the chain samples them on the
// falling edge.
//
// Parameters
//   WIDTH       number of T stages driven
//   MAX         terminal value, MAX <= 2**WIDTH-1
//
// Ports
//   CLK         system clock; rising edge here, falling edge in the chain
//   CLR         synchronous active-high reset
//   EN          count enable, honoured only while running
//   UP          count direction, 1 = up, 0 = down
//   LOAD_VALID  load request
//   LOAD_VAL    value to load, clamped to MAX
//   LOAD_READY  high while running (a load can be accepted)
//   Q_FB        Q vector fed back from the chain
//   T_OUT       per-bit toggle enables to the chain (combinational)
//   CLR_OUT     per-bit asynchronous clear to the chain (registered)
//   PRESET_OUT  per-bit asynchronous preset to the chain (registered)
//   TC          terminal count, high in the cycle whose falling edge wraps
//   COUNT_VALID high while running; Q_FB holds a legal count
// -----------------------------------------------------------------------------
module tff_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] Q_FB,
    output logic [WIDTH-1:0] T_OUT,
    output logic [WIDTH-1:0] CLR_OUT,
    output logic [WIDTH-1:0] PRESET_OUT,
    output logic             TC,
    output logic             COUNT_VALID
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] clr_out_r;
    logic [WIDTH-1:0] preset_out_r;
    logic             load_ready_r;
    logic             count_valid_r;

    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] next_val_s;
    logic             run_s;
    logic [WIDTH-1:0] t_out_s;
    logic             tc_s;

    // Successor of q in the 0..MAX ring. Anything above MAX is treated as
    // corrupt and recovers to the value the direction would wrap to.
    function automatic logic [WIDTH-1:0] next_value(
        input logic [WIDTH-1:0] q,
        input logic             up
    );
        logic [WIDTH-1:0] nv;
        if (up) begin
            if (q >= MAX_V) begin
                nv = ZERO_V;
            end else begin
                nv = q + ONE_V;
            end
        end else begin
            if ((q == ZERO_V) || (q > MAX_V)) begin
                nv = MAX_V;
            end else begin
                nv = q - ONE_V;
            end
        end
        return nv;
    endfunction

    // Load values above MAX would put the chain outside the count ring.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        if (v > MAX_V) begin
            c = MAX_V;
        end else begin
            c = v;
        end
        return c;
    endfunction

    // Terminal count only for in-range wrap points; a corrupt Q does not count.
    function automatic logic is_terminal(
        input logic [WIDTH-1:0] q,
        input logic             up
    );
        logic hit;
        if (up) begin
            hit = (q == MAX_V);
        end else begin
            hit = (q == ZERO_V);
        end
        return hit;
    endfunction

    assign load_clamped_s = clamp_load(LOAD_VAL);

    // Sequencer: state, registered clear/preset strobes and status flags.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r       <= ST_CLEAR;
            clr_out_r     <= ONES_V;
            preset_out_r  <= ZERO_V;
            load_ready_r  <= 1'b0;
            count_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    state_r       <= ST_SETTLE;
                    clr_out_r     <= ZERO_V;
                    preset_out_r  <= ZERO_V;
                    load_ready_r  <= 1'b0;
                    count_valid_r <= 1'b0;
                end
                ST_SETTLE: begin
                    state_r       <= ST_RUN;
                    clr_out_r     <= ZERO_V;
                    preset_out_r  <= ZERO_V;
                    load_ready_r  <= 1'b1;
                    count_valid_r <= 1'b1;
                end
                ST_RUN: begin
                    if (LOAD_VALID) begin
                        // Complementary strobes: every bit is forced exactly
                        // one way, and no bit ever sees clear and preset at once.
                        state_r       <= ST_LOAD;
                        clr_out_r     <= ~load_clamped_s;
                        preset_out_r  <= load_clamped_s;
                        load_ready_r  <= 1'b0;
                        count_valid_r <= 1'b0;
                    end else begin
                        state_r       <= ST_RUN;
                        clr_out_r     <= ZERO_V;
                        preset_out_r  <= ZERO_V;
                        load_ready_r  <= 1'b1;
                        count_valid_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_r       <= ST_SETTLE;
                    clr_out_r     <= ZERO_V;
                    preset_out_r  <= ZERO_V;
                    load_ready_r  <= 1'b0;
                    count_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_CLEAR;
                    clr_out_r     <= ONES_V;
                    preset_out_r  <= ZERO_V;
                    load_ready_r  <= 1'b0;
                    count_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Toggle enables and terminal count, derived from the live chain state.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        next_val_s = next_value(Q_FB, UP);
        t_out_s    = ZERO_V;
        tc_s       = 1'b0;
        if (run_s && EN) begin
            // Flipping exactly the differing bits lands the chain on next_val_s.
            t_out_s = Q_FB ^ next_val_s;
            tc_s    = is_terminal(Q_FB, UP);
        end else begin
            t_out_s = ZERO_V;
            tc_s    = 1'b0;
        end
    end

    assign T_OUT       = t_out_s;
    assign TC          = tc_s;
    assign CLR_OUT     = clr_out_r;
    assign PRESET_OUT  = preset_out_r;
    assign LOAD_READY  = load_ready_r;
    assign COUNT_VALID = count_valid_r;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl. A behavioural model of the falling-edge T chain
// closes the loop so Q_FB is real. A counter model predicts every output each
// cycle; directed checks pin the values worked out by hand.
module tb_tff_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;

    logic             CLK = 1'b0;
    logic             CLR;
    logic             EN;
    logic             UP;
    logic             LOAD_VALID;
    logic [WIDTH-1:0] LOAD_VAL;
    logic             LOAD_READY;
    logic [WIDTH-1:0] Q_FB;
    logic [WIDTH-1:0] T_OUT;
    logic [WIDTH-1:0] CLR_OUT;
    logic [WIDTH-1:0] PRESET_OUT;
    logic             TC;
    logic             COUNT_VALID;

    logic [WIDTH-1:0] q_chain;
    logic             inj_en;
    logic [WIDTH-1:0] inj_val;

    int n_tests = 0;
    int n_fail  = 0;

    tff_counter_ctrl #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP),
        .LOAD_VALID(LOAD_VALID), .LOAD_VAL(LOAD_VAL), .LOAD_READY(LOAD_READY),
        .Q_FB(Q_FB), .T_OUT(T_OUT), .CLR_OUT(CLR_OUT), .PRESET_OUT(PRESET_OUT),
        .TC(TC), .COUNT_VALID(COUNT_VALID)
    );

    always #10 CLK = ~CLK;

    // Falling-edge T flip-flops with asynchronous clear (dominant) and preset.
    for (genvar g = 0; g < WIDTH; g++) begin : g_chain
        logic q_bit;
        always @(negedge CLK or posedge CLR_OUT[g] or posedge PRESET_OUT[g]) begin
            if (CLR_OUT[g]) q_bit <= 1'b0;
            else if (PRESET_OUT[g]) q_bit <= 1'b1;
            else q_bit <= q_bit ^ T_OUT[g];
        end
        assign q_chain[g] = q_bit;
    end

    // Injection lets a corrupt Q be presented without disturbing the chain.
    assign Q_FB = inj_en ? inj_val : q_chain;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Successor in the 0..MAX ring, by modular arithmetic.
    function automatic int model_nv(input int q, input bit up);
        if (q > MAX) return up ? 0 : MAX;
        return up ? (q + 1) % (MAX + 1) : (q + MAX) % (MAX + 1);
    endfunction

    // Model: m_nonrun counts the remaining cycles before counting resumes.
    int               m_q      = 0;
    int               m_next_q = 0;
    int               m_nonrun = 2;
    logic [WIDTH-1:0] m_clr    = 4'h0;
    logic [WIDTH-1:0] m_pre    = 4'h0;
    bit               m_run;
    logic [WIDTH-1:0] m_t;
    bit               m_tc;

    // Compare process: advance the model on each rising edge, check mid-cycle.
    always @(posedge CLK) begin
        if (CLR) begin
            m_q = 0; m_nonrun = 2; m_clr = 4'hF; m_pre = 4'h0;
        end else if (m_nonrun > 0) begin
            m_q = m_next_q; m_nonrun = m_nonrun - 1; m_clr = 4'h0; m_pre = 4'h0;
        end else if (LOAD_VALID) begin
            m_q = (int'(LOAD_VAL) > MAX) ? MAX : int'(LOAD_VAL);
            m_nonrun = 2;
            m_pre = 4'(m_q);
            m_clr = ~m_pre;
        end else begin
            m_q = m_next_q; m_clr = 4'h0; m_pre = 4'h0;
        end
        #3;
        m_run = (m_nonrun == 0);
        m_t   = (m_run && EN) ? 4'(m_q ^ model_nv(m_q, UP)) : 4'h0;
        m_tc  = m_run && EN && (UP ? (m_q == MAX) : (m_q == 0));
        check("mdl_q",      32'(Q_FB),        32'(m_q));
        check("mdl_t",      32'(T_OUT),       32'(m_t));
        check("mdl_tc",     32'(TC),          32'(m_tc));
        check("mdl_valid",  32'(COUNT_VALID), 32'(m_run));
        check("mdl_ready",  32'(LOAD_READY),  32'(m_run));
        check("mdl_clr",    32'(CLR_OUT),     32'(m_clr));
        check("mdl_pre",    32'(PRESET_OUT),  32'(m_pre));
        m_next_q = (m_run && EN) ? model_nv(m_q, UP) : m_q;
    end

    // Inputs change 1 time unit after the rising edge; checks follow at +4.
    task automatic drive(input logic clr, input logic en, input logic up,
                         input logic lv, input logic [WIDTH-1:0] val);
        @(posedge CLK);
        #1;
        CLR = clr; EN = en; UP = up; LOAD_VALID = lv; LOAD_VAL = val;
    endtask

    initial begin
        CLR = 1'b1; EN = 1'b0; UP = 1'b1; LOAD_VALID = 1'b0; LOAD_VAL = 4'h0;
        inj_en = 1'b0; inj_val = 4'h0;

        // Reset held for three edges, then released.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("rst_clr_out", 32'(CLR_OUT), 32'(4'hF));
        check("rst_valid", 32'(COUNT_VALID), 32'(1'b0));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("post_rst_clr_out", 32'(CLR_OUT), 32'(4'hF));
        check("post_rst_ready", 32'(LOAD_READY), 32'(1'b0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("settle_clr_out", 32'(CLR_OUT), 32'(4'h0));
        check("settle_valid", 32'(COUNT_VALID), 32'(1'b0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
        check("run_valid", 32'(COUNT_VALID), 32'(1'b1));
        check("run_q0", 32'(Q_FB), 32'(4'h0));

        // Up count 1..9 with TC only at 9.
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
            check("up_q", 32'(Q_FB), 32'(i));
            check("up_tc", 32'(TC), 32'(i == 9));
            if (i == 9) check("up_t_at_max", 32'(T_OUT), 32'(4'b1001));
        end

        // Wrapped to 0; now count down: 0 -> 9 -> ... -> 3.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0); #3;
        check("dn_q0", 32'(Q_FB), 32'(4'h0));
        check("dn_tc0", 32'(TC), 32'(1'b1));
        check("dn_t0", 32'(T_OUT), 32'(4'b1001));
        for (int k = 9; k >= 3; k--) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0); #3;
            check("dn_q", 32'(Q_FB), 32'(k));
            check("dn_tc", 32'(TC), 32'(1'b0));
        end

        // Load 6 at Q=2 while also counting.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd6); #3;
        check("ld_q2", 32'(Q_FB), 32'(4'd2));
        check("ld_ready_run", 32'(LOAD_READY), 32'(1'b1));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
        check("ld_preset", 32'(PRESET_OUT), 32'(4'b0110));
        check("ld_clr", 32'(CLR_OUT), 32'(4'b1001));
        check("ld_q6", 32'(Q_FB), 32'(4'd6));
        check("ld_ready_lo1", 32'(LOAD_READY), 32'(1'b0));
        check("ld_t_zero", 32'(T_OUT), 32'(4'h0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
        check("ld_ready_lo2", 32'(LOAD_READY), 32'(1'b0));
        check("ld_settle_q6", 32'(Q_FB), 32'(4'd6));
        check("ld_settle_pre", 32'(PRESET_OUT), 32'(4'h0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
        check("ld_resume_ready", 32'(LOAD_READY), 32'(1'b1));
        check("ld_resume_q6", 32'(Q_FB), 32'(4'd6));

        // Clamp: request 14, expect 9; then hold for four cycles.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd14); #3;
        check("cl_q7", 32'(Q_FB), 32'(4'd7));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("cl_q9", 32'(Q_FB), 32'(4'd9));
        check("cl_preset", 32'(PRESET_OUT), 32'(4'b1001));
        check("cl_clr", 32'(CLR_OUT), 32'(4'b0110));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int h = 0; h < 4; h++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
            check("hold_t", 32'(T_OUT), 32'(4'h0));
            check("hold_q9", 32'(Q_FB), 32'(4'd9));
        end

        // Corrupt Q presented briefly, before the falling edge.
        #1; inj_en = 1'b1; inj_val = 4'd12; EN = 1'b1; UP = 1'b1;
        #1; check("oor_up_t", 32'(T_OUT), 32'(4'b1100));
        check("oor_up_tc", 32'(TC), 32'(1'b0));
        UP = 1'b0;
        #1; check("oor_dn_t", 32'(T_OUT), 32'(4'b0101));
        check("oor_dn_tc", 32'(TC), 32'(1'b0));
        EN = 1'b0; UP = 1'b1; inj_en = 1'b0; inj_val = 4'h0;

        // Reset during a load discards the pending preset.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5); #3;
        check("rl_q9", 32'(Q_FB), 32'(4'd9));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("rl_q5", 32'(Q_FB), 32'(4'd5));
        check("rl_preset", 32'(PRESET_OUT), 32'(4'b0101));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("rl_clr_out", 32'(CLR_OUT), 32'(4'hF));
        check("rl_preset0", 32'(PRESET_OUT), 32'(4'h0));
        check("rl_q0", 32'(Q_FB), 32'(4'h0));
        check("rl_valid", 32'(COUNT_VALID), 32'(1'b0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("rl_settle_valid", 32'(COUNT_VALID), 32'(1'b0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); #3;
        check("rl_run_valid", 32'(COUNT_VALID), 32'(1'b1));
        check("rl_run_q0", 32'(Q_FB), 32'(4'h0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0); #3;
        check("rl_run_q1", 32'(Q_FB), 32'(4'd1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
